// File: rtl/cdb_arbiter.sv
// Round-robin arbiter in front of the common data bus: picks one finished FU per
// cycle and drives the broadcast select/tag and a one-cycle acknowledge from registers.
module cdb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int TAG_W  = 5
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [NUM_FU-1:0]             fu_done,
  input  logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag,
  output logic [NUM_FU-1:0]             fu_ack,
  output logic                          select_flag,
  output logic [2:0]                    select,
  output logic [TAG_W-1:0]              ROB_tag
);

  localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [PW-1:0]       r_ptr;
  logic [NUM_FU-1:0]   r_ack;
  logic                r_selectFlag;
  logic [2:0]          r_select;
  logic [TAG_W-1:0]    r_robTag;

  logic [NUM_FU-1:0]   w_req;
  logic                w_hiFound;
  logic                w_loFound;
  logic [PW-1:0]       w_hiIdx;
  logic [PW-1:0]       w_loIdx;
  logic [PW-1:0]       w_grantIdx;
  logic                w_grant;
  logic [PW-1:0]       w_ptrNext;
  logic [NUM_FU-1:0]   w_ackNext;

  // The FU currently being acknowledged still shows done for its old result, so mask it.
  assign w_req = fu_done & ~r_ack;

  // Two-window priority search: lowest requester at or above the pointer wins,
  // otherwise the lowest requester below it (wraps modulo NUM_FU, not a power of two).
  always_comb begin
    w_hiFound = 1'b0;
    w_loFound = 1'b0;
    w_hiIdx   = '0;
    w_loIdx   = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_loFound = 1'b1;
        w_loIdx   = PW'(i);
        if (i >= int'(r_ptr)) begin
          w_hiFound = 1'b1;
          w_hiIdx   = PW'(i);
        end
      end
    end
  end

  assign w_grantIdx = w_hiFound ? w_hiIdx : w_loIdx;
  assign w_grant    = w_loFound && !flush;
  assign w_ptrNext  = (w_grantIdx == PW'(NUM_FU - 1)) ? '0 : (w_grantIdx + PW'(1));

  always_comb begin
    w_ackNext = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_ackNext[i] = w_grant && (w_grantIdx == PW'(i));
    end
  end

  // Grant registers; flush and an empty request vector both clear the broadcast.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_ack        <= '0;
      r_selectFlag <= 1'b0;
      r_select     <= 3'd0;
      r_robTag     <= '0;
    end else if (w_grant) begin
      r_ptr        <= w_ptrNext;
      r_ack        <= w_ackNext;
      r_selectFlag <= 1'b1;
      r_select     <= 3'(w_grantIdx);
      r_robTag     <= fu_tag[w_grantIdx];
    end else begin
      r_ack        <= '0;
      r_selectFlag <= 1'b0;
      r_select     <= 3'd0;
      r_robTag     <= '0;
    end
  end

  assign fu_ack      = r_ack;
  assign select_flag = r_selectFlag;
  assign select      = r_select;
  assign ROB_tag     = r_robTag;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// compared against a queue-free round-robin model kept in plain arithmetic.
module tb_cdb_arbiter;

  localparam int N = 5;
  localparam int TW = 5;

  logic                  clock;
  logic                  reset;
  logic                  flush;
  logic [N-1:0]          fuDone;
  logic [N-1:0][TW-1:0]  fuTag;
  logic [N-1:0]          fuAck;
  logic                  selectFlag;
  logic [2:0]            selectIdx;
  logic [TW-1:0]         robTag;

  int vectors;
  int miscompares;

  // Reference model state
  int           mPtr;
  logic [N-1:0] mAck;
  logic         mFlag;
  int           mSel;
  logic [TW-1:0] mTag;

  cdb_arbiter #(.NUM_FU(N), .TAG_W(TW)) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .fu_done     (fuDone),
    .fu_tag      (fuTag),
    .fu_ack      (fuAck),
    .select_flag (selectFlag),
    .select      (selectIdx),
    .ROB_tag     (robTag)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic modelReset();
    mPtr  = 0;
    mAck  = '0;
    mFlag = 1'b0;
    mSel  = 0;
    mTag  = '0;
  endtask

  // One clock edge of the behavioural arbiter, from the inputs seen at that edge.
  task automatic modelEdge(input logic [N-1:0] done, input logic fl,
                           input logic [N-1:0][TW-1:0] tags);
    logic [N-1:0] req;
    int g;
    bit found;
    req = done & ~mAck;
    found = 0;
    g = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(mPtr + k) % N]) begin
        found = 1;
        g = (mPtr + k) % N;
      end
    end
    if (fl || !found) begin
      mAck = '0; mFlag = 1'b0; mSel = 0; mTag = '0;
    end else begin
      mAck = '0;
      mAck[g] = 1'b1;
      mFlag = 1'b1;
      mSel = g;
      mTag = tags[g];
      mPtr = (g + 1) % N;
    end
  endtask

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    check1({tag, ".flag"}, 32'(selectFlag), 32'(mFlag));
    check1({tag, ".sel"},  32'(selectIdx),  32'(mSel));
    check1({tag, ".tag"},  32'(robTag),     32'(mTag));
    check1({tag, ".ack"},  32'(fuAck),      32'(mAck));
  endtask

  task automatic applyStimulus(input logic [N-1:0] done, input logic fl, input string tag);
    fuDone = done;
    flush  = fl;
    @(posedge clock);
    modelEdge(done, fl, fuTag);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    flush = 1'b0;
    fuDone = '0;
    fuTag = '0;
    modelReset();
    #11;
    checkOutput("reset");
    reset = 1'b0;

    // Single request from FU 2, explicit values as well as the model.
    fuTag[2] = 5'd7;
    applyStimulus(5'b00100, 1'b0, "single");
    check1("single.selConst", 32'(selectIdx), 32'd2);
    check1("single.tagConst", 32'(robTag), 32'd7);
    check1("single.ackConst", 32'(fuAck), 32'h04);
    applyStimulus(5'b00000, 1'b0, "single.idle");
    check1("single.idleFlag", 32'(selectFlag), 32'd0);

    // All five request; each drops done the cycle after its ack.
    reset = 1'b1; #1; modelReset(); reset = 1'b0;
    for (int i = 0; i < N; i++) fuTag[i] = TW'(10 + i);
    begin
      logic [N-1:0] pend;
      pend = '1;
      for (int c = 0; c < 6; c++) begin
        pend = pend & ~fuAck;
        applyStimulus(pend, 1'b0, "all5");
        if (c < N) check1("all5.order", 32'(selectIdx), 32'(c));
      end
    end

    // Grant FU 3 alone so the pointer sits at 4, then hold FUs 0 and 4.
    applyStimulus(5'b01000, 1'b0, "wrap.pre");
    applyStimulus(5'b00000, 1'b0, "wrap.gap");
    for (int c = 0; c < 6; c++) begin
      applyStimulus(5'b10001, 1'b0, "wrap");
      check1("wrap.alt", 32'(selectIdx), (c % 2 == 0) ? 32'd4 : 32'd0);
    end
    applyStimulus(5'b00000, 1'b0, "wrap.idle");

    // Continuous single requester: grant every other cycle with fresh tags.
    for (int k = 0; k < 6; k++) begin
      fuTag[1] = TW'(k / 2 + 1);
      applyStimulus(5'b00010, 1'b0, "cont");
      check1("cont.flag", 32'(selectFlag), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    applyStimulus(5'b00000, 1'b0, "cont.idle");

    // Flush squashes a live request; pointer must survive for the next grant.
    applyStimulus(5'b00101, 1'b1, "flush");
    check1("flush.flag", 32'(selectFlag), 32'd0);
    applyStimulus(5'b00101, 1'b0, "flush.after");

    // Async reset mid-grant, then the lowest eligible FU wins.
    applyStimulus(5'b01010, 1'b0, "midgrant");
    #1 reset = 1'b1;
    modelReset();
    #1;
    checkOutput("asyncRst");
    #1 reset = 1'b0;
    applyStimulus(5'b01010, 1'b0, "postRst");
    check1("postRst.low", 32'(selectIdx), 32'd1);

    // Random traffic with occasional flush and asynchronous reset.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) fuTag[i] = TW'($urandom);
      applyStimulus(N'($urandom), ($urandom_range(0, 9) == 0), "rand");
      if ($urandom_range(0, 49) == 0) begin
        #1 reset = 1'b1;
        modelReset();
        #1;
        checkOutput("rand.rst");
        #1 reset = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that sits directly upstream of the CDB. Each cycle it picks one of up to five functional units with a finished result and drives the CDB's `select_flag`, `select` and `ROB_tag` inputs from registers. It returns a one-cycle acknowledge to the winning FU. It owns the only sequential state on the broadcast path: the round-robin pointer and the registered grant.

## Interface
- `NUM_FU`, default 5: number of requesting FUs. Legal range 2..8; `select` stays 3 bits.
- `TAG_W`, default 5: ROB tag width.

Ports:
- `clock`: in, 1. Single clock. All state changes on the rising edge.
- `reset`: in, 1. Asynchronous, active-high.
- `flush`: in, 1. Synchronous squash from the ROB (mispredict).
- `fu_done`: in, `NUM_FU`. Bit i high means FU i holds a finished result.
- `fu_tag`: in, `NUM_FU` x `TAG_W`. ROB tag of FU i's result; valid while `fu_done[i]` is high.
- `fu_ack`: out, `NUM_FU`. One-hot, registered. FU i's result is on the CDB this cycle.
- `select_flag`: out, 1. Registered. Broadcast valid, to the CDB.
- `select`: out, 3. Registered. Index of the broadcasting FU, to the CDB.
- `ROB_tag`: out, `TAG_W`. Registered. Tag of the broadcasting FU, to the CDB.

## Operation
- FU contract:
  - The FU raises `fu_done[i]` and holds its result and `fu_tag[i]` stable through the cycle in which `fu_ack[i]` is high.
  - In the following cycle the FU may drop `fu_done` or present a new result.
- Eligible request vector: `req = fu_done & ~fu_ack`. The FU being acknowledged this cycle is masked, because its `done` is still high for the old result.
- Round-robin pointer `ptr` (width ceil(log2 `NUM_FU`)):
  - Search order is `ptr`, `ptr`+1, …, `NUM_FU`-1, 0, …, `ptr`-1, wrapping modulo `NUM_FU`, not modulo a power of two.
  - The first eligible index is the winner `g`.
- On a clock edge with at least one eligible request and `flush` low:
  - `select_flag` goes to 1, `select` to `g`, `ROB_tag` to `fu_tag[g]`, and `fu_ack` to one-hot(`g`).
  - `ptr` becomes (`g`+1) mod `NUM_FU`.
- On a clock edge with no eligible request:
  - `select_flag` goes to 0 and `fu_ack` to 0.
  - `select` and `ROB_tag` go to 0.
  - `ptr` is unchanged.
- On a clock edge with `flush` high:
  - `select_flag`, `select`, `ROB_tag` and `fu_ack` all go to 0.
  - No grant is issued and `ptr` is unchanged.
  - `flush` overrides any simultaneous request.
- Reset (async, any time, including mid-grant):
  - `select_flag`, `select`, `ROB_tag`, `fu_ack` and `ptr` go to 0 immediately.
  - After `reset` deasserts, the first grant searches from index 0.
- `fu_tag` of FUs that are not selected is ignored. A value on `fu_tag[i]` while `fu_done[i]` is low has no effect.
- Invariants:
  - At most one bit of `fu_ack` is set.
  - `fu_ack` is nonzero if and only if `select_flag` is 1.
  - When `select_flag` is 1, `fu_ack[select]` is 1.

## Timing
- Request-to-broadcast latency: 1 cycle. If `fu_done[i]` is first high in cycle t and FU i wins, then `select_flag` is 1 with `select`=i in cycle t+1.
- Sustained throughput: one broadcast per cycle while two or more FUs are requesting.
- A single FU with `fu_done` held continuously high is granted every other cycle, because of the ack-cycle mask.
- Worst-case wait for a requesting FU: `NUM_FU` cycles.
- No combinational path from any input to any output.

## Test plan
- Reset, then single request:
  - Stimulus: `fu_done`=5'b00100, `fu_tag[2]`=7 in cycle 1.
  - Required: in cycle 2, `select_flag`=1, `select`=2, `ROB_tag`=7, `fu_ack`=5'b00100. In cycle 3 (FU drops done), all outputs are 0.
- All five request from reset:
  - Stimulus: tags 10..14; each FU drops `done` the cycle after its ack.
  - Required: grants 0,1,2,3,4 on consecutive cycles with matching tags, then idle.
- Wrap and fairness:
  - Stimulus: `ptr`=4 after granting FU 3; `fu_done`=5'b10001 held.
  - Required: grants alternate 4,0,4,0,…
- Continuous single requester:
  - Stimulus: `fu_done[1]` held high for 6 cycles with new tags 1..3.
  - Required: `select_flag` pattern 1,0,1,0,1,0, `select`=1, tags 1,2,3.
- Flush:
  - Stimulus: `flush` asserted while FUs 0 and 2 request.
  - Required: next cycle all outputs 0, `ptr` unchanged. With `flush` low, the following cycle grants the FU the unchanged pointer selects.
- Async reset mid-grant:
  - Stimulus: assert `reset` between edges while `select_flag`=1.
  - Required: all outputs are 0 before the next edge. After release, the first grant goes to the lowest-indexed eligible FU.
